multibyte_sub_seq: RTL

//  Sequential multi-byte subtractor: computes op_a - op_b over NBYTES bytes, LSB byte first.

---
 rtl/multibyte_sub_seq_pkg.sv | 23 ++
 rtl/multibyte_sub_seq_adder8.sv | 20 ++
 rtl/multibyte_sub_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/multibyte_sub_seq_pkg.sv
// ============================================================================
// Module  : multibyte_sub_seq_pkg
// Brief   : Shared constants for the sequential multi-byte subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multibyte_sub_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Byte-index counter width; a single-byte operand still needs one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage : multibyte_sub_seq_pkg

`default_nettype wire

// File: rtl/multibyte_sub_seq_adder8.sv
// ============================================================================
// Module  : adder8
// Brief   : 8-bit ripple stage: {cout, s} = a + b + cin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule : adder8

`default_nettype wire

// File: rtl/multibyte_sub_seq.sv
// ============================================================================
// Module  : multibyte_sub_seq
// Brief   : Byte-serial op_a - op_b through one adder8, LSB byte first.
//           Optional signed-overflow flag enabled by macro SUB_OVERFLOW_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multibyte_sub_seq
    import multibyte_sub_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NBYTES*BYTE_W-1:0] op_a,
    input  logic [NBYTES*BYTE_W-1:0] op_b,
    output logic                     busy,
    output logic                     done,
    output logic [NBYTES*BYTE_W-1:0] diff,
    output logic                     borrow_out,
    output logic                     ovf
);

    localparam int                W    = NBYTES * BYTE_W;
    localparam int                IDXW = idx_width(NBYTES);
    localparam logic [IDXW-1:0]   LAST = IDXW'(NBYTES - 1);

    logic [1:0]        state_q,  state_d;
    logic [IDXW-1:0]   idx_q,    idx_d;
    logic              carry_q,  carry_d;
    logic [W-1:0]      a_q,      a_d;
    logic [W-1:0]      b_q,      b_d;
    logic [W-1:0]      diff_q,   diff_d;
    logic              done_q,   done_d;
    logic              borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
    logic              ovf_q,    ovf_d;
`endif

    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_sum;
    logic              w_cout;

    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == IDXW'(k)) begin
                w_a_byte = a_q[k*BYTE_W +: BYTE_W];
                w_b_byte = b_q[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Subtraction as A + ~B + 1; the carry register seeds the +1 and chains borrows.
    adder8 u_adder8 (
        .a    (w_a_byte),
        .b    (~w_b_byte),
        .cin  (carry_q),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    state_d = S_RUN;
`ifdef SUB_OVERFLOW_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        diff_d[k*BYTE_W +: BYTE_W] = w_sum;
                    end
                end
                carry_d = w_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                borrow_d = ~carry_q;
`ifdef SUB_OVERFLOW_EN
                ovf_d    = (a_q[W-1] != b_q[W-1]) & (diff_q[W-1] != a_q[W-1]);
`endif
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign ovf        = ovf_q;
`else
    assign ovf        = 1'b0;
`endif

endmodule : multibyte_sub_seq

`default_nettype wire
